// File: rtl/sampler_voice_mixer.sv
// Multi-voice sample playback mixer: per frame, fetches one stereo sample per active
// voice, scales by voice volume, sums, saturates and pushes the mix to the codec FIFO.
module sampler_voice_mixer #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned SAMPLE_W   = 24,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned VOL_W      = 8,
  localparam int unsigned VIDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_wr,
  input  logic [VIDX_W-1:0]       cfg_voice,
  input  logic [ADDR_W-1:0]       cfg_start_addr,
  input  logic [ADDR_W-1:0]       cfg_end_addr,
  input  logic [VOL_W-1:0]        cfg_volume,
  input  logic                    cfg_loop,
  input  logic [NUM_VOICES-1:0]   voice_trigger,
  input  logic [NUM_VOICES-1:0]   voice_stop,
  input  logic                    frame_req,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_rd_addr,
  input  logic [2*SAMPLE_W-1:0]   mem_rd_data,
  output logic [2*SAMPLE_W-1:0]   data_out,
  output logic                    data_wr,
  input  logic                    fifo_full,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic                    clip,
  output logic                    frame_drop,
  input  logic                    flag_clr
);

  localparam int unsigned ACC_W  = SAMPLE_W + VOL_W + $clog2(NUM_VOICES) + 1;
  localparam int unsigned PROD_W = SAMPLE_W + VOL_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ACCUM, S_SAT, S_OUT} state_e;

  state_e                  state_q;
  logic [VIDX_W-1:0]       vidx_q;
  logic [VIDX_W-1:0]       vidx_next;
  logic [ACC_W-1:0]        acc_l_q, acc_r_q;
  logic                    rd_pend_q;
  logic                    mem_rd_en_q;
  logic [ADDR_W-1:0]       mem_rd_addr_q;
  logic [2*SAMPLE_W-1:0]   data_out_q;
  logic                    data_wr_q;
  logic                    clip_q, frame_drop_q;

  logic [ADDR_W-1:0]       start_q [NUM_VOICES];
  logic [ADDR_W-1:0]       end_q   [NUM_VOICES];
  logic [VOL_W-1:0]        vol_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0]   loop_q;
  logic [ADDR_W-1:0]       cur_q   [NUM_VOICES];
  logic [ADDR_W-1:0]       cur_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0]   active_q, active_d;

  logic                    adv_en;
  logic [ACC_W-1:0]        scaled_l, scaled_r;
  logic [SAMPLE_W-1:0]     sat_l, sat_r;
  logic                    ovf_l, ovf_r;

  // Signed sample times unsigned volume, arithmetic shift back to sample scale.
  function automatic logic [ACC_W-1:0] scale(input logic [SAMPLE_W-1:0] s,
                                             input logic [VOL_W-1:0]    vol);
    logic signed [PROD_W-1:0] p;
    p = $signed({{(VOL_W+1){s[SAMPLE_W-1]}}, s}) * $signed({{(SAMPLE_W+1){1'b0}}, vol});
    return ACC_W'(p >>> VOL_W);
  endfunction

  function automatic logic ovf(input logic [ACC_W-1:0] a);
    return !((&a[ACC_W-1:SAMPLE_W-1]) || !(|a[ACC_W-1:SAMPLE_W-1]));
  endfunction

  function automatic logic [SAMPLE_W-1:0] clamp(input logic [ACC_W-1:0] a);
    if (!ovf(a)) return a[SAMPLE_W-1:0];
    return a[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction

  assign vidx_next = vidx_q + VIDX_W'(1);
  assign adv_en    = (state_q == S_ACCUM) && active_q[vidx_q];
  assign scaled_l  = scale(mem_rd_data[2*SAMPLE_W-1:SAMPLE_W], vol_q[vidx_q]);
  assign scaled_r  = scale(mem_rd_data[SAMPLE_W-1:0], vol_q[vidx_q]);
  assign sat_l     = clamp(acc_l_q);
  assign sat_r     = clamp(acc_r_q);
  assign ovf_l     = ovf(acc_l_q);
  assign ovf_r     = ovf(acc_r_q);

  // Per-voice playback pointer: trigger beats advance, stop beats everything.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      cur_d[v]    = cur_q[v];
      active_d[v] = active_q[v];
      if (voice_trigger[v]) begin
        cur_d[v]    = start_q[v];
        active_d[v] = 1'b1;
      end else if (adv_en && (vidx_q == VIDX_W'(v))) begin
        if (cur_q[v] != end_q[v]) begin
          cur_d[v] = cur_q[v] + ADDR_W'(1);
        end else if (loop_q[v]) begin
          cur_d[v] = start_q[v];
        end else begin
          active_d[v] = 1'b0;
        end
      end
      if (voice_stop[v]) active_d[v] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      vidx_q        <= '0;
      acc_l_q       <= '0;
      acc_r_q       <= '0;
      rd_pend_q     <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      data_out_q    <= '0;
      data_wr_q     <= 1'b0;
      clip_q        <= 1'b0;
      frame_drop_q  <= 1'b0;
      loop_q        <= '0;
      active_q      <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        start_q[v] <= '0;
        end_q[v]   <= '0;
        vol_q[v]   <= '0;
        cur_q[v]   <= '0;
      end
    end else begin
      if (cfg_wr && (32'(cfg_voice) < NUM_VOICES)) begin
        start_q[cfg_voice] <= cfg_start_addr;
        end_q[cfg_voice]   <= cfg_end_addr;
        vol_q[cfg_voice]   <= cfg_volume;
        loop_q[cfg_voice]  <= cfg_loop;
      end
      for (int v = 0; v < NUM_VOICES; v++) cur_q[v] <= cur_d[v];
      active_q    <= active_d;
      rd_pend_q   <= mem_rd_en_q;
      mem_rd_en_q <= 1'b0;
      data_wr_q   <= 1'b0;

      if (frame_req && (state_q != S_IDLE)) frame_drop_q <= 1'b1;
      else if (flag_clr)                    frame_drop_q <= 1'b0;
      if ((state_q == S_SAT) && (ovf_l || ovf_r)) clip_q <= 1'b1;
      else if (flag_clr)                          clip_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (frame_req) begin
            state_q       <= S_FETCH;
            vidx_q        <= '0;
            acc_l_q       <= '0;
            acc_r_q       <= '0;
            mem_rd_en_q   <= active_d[0];
            mem_rd_addr_q <= cur_d[0];
          end
        end
        S_FETCH: state_q <= S_ACCUM;
        S_ACCUM: begin
          // Only add data that was actually fetched for a still-playing voice.
          if (rd_pend_q && active_q[vidx_q]) begin
            acc_l_q <= acc_l_q + scaled_l;
            acc_r_q <= acc_r_q + scaled_r;
          end
          if (vidx_q == VIDX_W'(NUM_VOICES - 1)) begin
            state_q <= S_SAT;
          end else begin
            state_q       <= S_FETCH;
            vidx_q        <= vidx_next;
            mem_rd_en_q   <= active_d[vidx_next];
            mem_rd_addr_q <= cur_d[vidx_next];
          end
        end
        S_SAT: begin
          data_out_q <= {sat_l, sat_r};
          state_q    <= S_OUT;
        end
        S_OUT: begin
          if (!fifo_full) begin
            data_wr_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd_en    = mem_rd_en_q;
  assign mem_rd_addr  = mem_rd_addr_q;
  assign data_out     = data_out_q;
  assign data_wr      = data_wr_q;
  assign voice_active = active_q;
  assign clip         = clip_q;
  assign frame_drop   = frame_drop_q;

endmodule

// File: tb/tb_sampler_voice_mixer.sv
// Directed bench for sampler_voice_mixer: one-shot, loop, wrap, mix, clip,
// FIFO back-pressure, trigger/stop priority and mid-frame reset.
module tb_sampler_voice_mixer;

  localparam int NV = 4;
  localparam int SW = 24;
  localparam int AW = 16;
  localparam int VW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cfg_wr = 1'b0;
  logic [1:0]      cfg_voice = '0;
  logic [AW-1:0]   cfg_start_addr = '0;
  logic [AW-1:0]   cfg_end_addr = '0;
  logic [VW-1:0]   cfg_volume = '0;
  logic            cfg_loop = 1'b0;
  logic [NV-1:0]   voice_trigger = '0;
  logic [NV-1:0]   voice_stop = '0;
  logic            frame_req = 1'b0;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_rd_addr;
  logic [2*SW-1:0] mem_rd_data = '0;
  logic [2*SW-1:0] data_out;
  logic            data_wr;
  logic            fifo_full = 1'b0;
  logic [NV-1:0]   voice_active;
  logic            clip;
  logic            frame_drop;
  logic            flag_clr = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  logic [2*SW-1:0] mem_word = '0;
  logic [AW-1:0]   addr_q[$];

  always #5 clk = ~clk;

  sampler_voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .ADDR_W(AW), .VOL_W(VW)) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_voice(cfg_voice),
    .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
    .cfg_volume(cfg_volume), .cfg_loop(cfg_loop), .voice_trigger(voice_trigger),
    .voice_stop(voice_stop), .frame_req(frame_req), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .data_out(data_out),
    .data_wr(data_wr), .fifo_full(fifo_full), .voice_active(voice_active),
    .clip(clip), .frame_drop(frame_drop), .flag_clr(flag_clr)
  );

  // Sample memory: one-cycle read latency, logs every address read.
  always @(posedge clk) begin
    if (mem_rd_en === 1'b1) begin
      mem_rd_data <= mem_word;
      addr_q.push_back(mem_rd_addr);
    end else begin
      mem_rd_data <= '0;
    end
  end

  task automatic do_reset();
    reset = 1'b0; cfg_wr = 1'b0; voice_trigger = '0; voice_stop = '0;
    frame_req = 1'b0; fifo_full = 1'b0; flag_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    addr_q.delete();
  endtask

  task automatic cfg(input int v, input logic [AW-1:0] s, input logic [AW-1:0] e,
                     input logic [VW-1:0] vol, input logic lp);
    cfg_wr = 1'b1; cfg_voice = 2'(v); cfg_start_addr = s; cfg_end_addr = e;
    cfg_volume = vol; cfg_loop = lp;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic trig(input logic [NV-1:0] m);
    voice_trigger = m;
    @(negedge clk);
    voice_trigger = '0;
  endtask

  // Pulses frame_req and waits (bounded) for the FIFO write; lat counts clock edges.
  task automatic run_frame(output logic [2*SW-1:0] d, output int lat, output bit ok);
    ok = 1'b0; lat = 0; d = '0;
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (data_wr === 1'b1) begin
        d = data_out; lat = k - 1; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (voice_active !== 4'h0) begin n_mis++; $display("FAIL reset_active: got %h expected 0", voice_active); end
    n_cmp++; if ({mem_rd_en, data_wr, clip, frame_drop} !== 4'b0) begin n_mis++; $display("FAIL reset_flags: got %b expected 0000", {mem_rd_en, data_wr, clip, frame_drop}); end
    n_cmp++; if (data_out !== '0) begin n_mis++; $display("FAIL reset_data: got %h expected 0", data_out); end
    do_reset();
  endtask

  task automatic test_oneshot();
    logic [2*SW-1:0] d, exp_d;
    int lat; bit ok;
    do_reset();
    mem_word = {24'(1000), 24'(-1000)};
    cfg(0, 16'h0010, 16'h0012, 8'd255, 1'b0);
    trig(4'b0001);
    n_cmp++; if (voice_active !== 4'b0001) begin n_mis++; $display("FAIL oneshot_trig: got %b expected 0001", voice_active); end
    exp_d = {24'(996), 24'(-997)};
    for (int f = 0; f < 3; f++) begin
      run_frame(d, lat, ok);
      n_cmp++; if (!ok || d !== exp_d) begin n_mis++; $display("FAIL oneshot_data%0d: got %h (ok=%0d) expected %h", f, d, ok, exp_d); end
      n_cmp++; if (lat !== 10) begin n_mis++; $display("FAIL oneshot_lat%0d: got %0d expected 10", f, lat); end
    end
    n_cmp++; if (voice_active !== 4'b0000) begin n_mis++; $display("FAIL oneshot_end: got %b expected 0000", voice_active); end
    run_frame(d, lat, ok);
    n_cmp++; if (!ok || d !== '0) begin n_mis++; $display("FAIL oneshot_silent: got %h (ok=%0d) expected 0", d, ok); end
    n_cmp++; if (addr_q.size() != 3 || addr_q[0] !== 16'h10 || addr_q[1] !== 16'h11 || addr_q[2] !== 16'h12) begin
      n_mis++; $display("FAIL oneshot_addrs: got %p expected 0x10,0x11,0x12", addr_q);
    end
    n_cmp++; if (clip !== 1'b0) begin n_mis++; $display("FAIL oneshot_clip: got %b expected 0", clip); end
  endtask

  task automatic test_loop();
    logic [2*SW-1:0] d;
    logic [AW-1:0] exp_a [5];
    int lat; bit ok;
    exp_a = '{16'h10, 16'h11, 16'h12, 16'h10, 16'h11};
    do_reset();
    mem_word = {24'(1000), 24'(-1000)};
    cfg(0, 16'h0010, 16'h0012, 8'd255, 1'b1);
    trig(4'b0001);
    for (int f = 0; f < 5; f++) begin
      run_frame(d, lat, ok);
      // rewriting config mid-playback must not disturb the play pointer
      if (f == 1) cfg(0, 16'h0010, 16'h0012, 8'd255, 1'b1);
    end
    n_cmp++; if (addr_q.size() != 5) begin n_mis++; $display("FAIL loop_count: got %0d expected 5", addr_q.size()); end
    for (int i = 0; i < 5 && i < addr_q.size(); i++) begin
      n_cmp++; if (addr_q[i] !== exp_a[i]) begin n_mis++; $display("FAIL loop_addr%0d: got %h expected %h", i, addr_q[i], exp_a[i]); end
    end
    n_cmp++; if (voice_active !== 4'b0001) begin n_mis++; $display("FAIL loop_active: got %b expected 0001", voice_active); end
  endtask

  task automatic test_wrap();
    logic [2*SW-1:0] d;
    int lat; bit ok;
    do_reset();
    cfg(0, 16'hFFFF, 16'h0001, 8'd255, 1'b0);
    trig(4'b0001);
    repeat (3) run_frame(d, lat, ok);
    n_cmp++; if (addr_q.size() != 3 || addr_q[0] !== 16'hFFFF || addr_q[1] !== 16'h0000 || addr_q[2] !== 16'h0001) begin
      n_mis++; $display("FAIL wrap_addrs: got %p expected ffff,0000,0001", addr_q);
    end
    n_cmp++; if (voice_active !== 4'b0000) begin n_mis++; $display("FAIL wrap_end: got %b expected 0000", voice_active); end
  endtask

  task automatic test_mix();
    logic [2*SW-1:0] d, exp_d;
    int lat; bit ok;
    do_reset();
    mem_word = {24'(1000), 24'(-1000)};
    cfg(0, 16'h0000, 16'h00FF, 8'd128, 1'b0);
    cfg(1, 16'h0100, 16'h01FF, 8'd64, 1'b0);
    trig(4'b0011);
    exp_d = {24'(750), 24'(-750)};
    run_frame(d, lat, ok);
    n_cmp++; if (!ok || d !== exp_d) begin n_mis++; $display("FAIL mix_data: got %h (ok=%0d) expected %h", d, ok, exp_d); end
    n_cmp++; if (addr_q.size() != 2 || addr_q[0] !== 16'h0000 || addr_q[1] !== 16'h0100) begin
      n_mis++; $display("FAIL mix_addrs: got %p expected 0000,0100", addr_q);
    end
  endtask

  task automatic test_clip();
    logic [2*SW-1:0] d, exp_d;
    int lat; bit ok;
    do_reset();
    mem_word = {24'h7FFFFF, 24'h800000};
    for (int v = 0; v < NV; v++) cfg(v, 16'h0000, 16'h00FF, 8'd255, 1'b0);
    trig(4'b1111);
    exp_d = {24'h7FFFFF, 24'h800000};
    run_frame(d, lat, ok);
    n_cmp++; if (!ok || d !== exp_d) begin n_mis++; $display("FAIL clip_data: got %h (ok=%0d) expected %h", d, ok, exp_d); end
    n_cmp++; if (clip !== 1'b1) begin n_mis++; $display("FAIL clip_set: got %b expected 1", clip); end
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    n_cmp++; if (clip !== 1'b0) begin n_mis++; $display("FAIL clip_clr: got %b expected 0", clip); end
  endtask

  task automatic test_back_to_back();
    logic [2*SW-1:0] exp_d;
    do_reset();
    mem_word = {24'(1000), 24'(-1000)};
    cfg(0, 16'h0010, 16'h0020, 8'd255, 1'b0);
    trig(4'b0001);
    exp_d = {24'(996), 24'(-997)};
    fifo_full = 1'b1;
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    repeat (9) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (data_wr !== 1'b0 || data_out !== exp_d) begin
        n_mis++; $display("FAIL hold%0d: got wr=%b data=%h expected wr=0 data=%h", i, data_wr, data_out, exp_d);
      end
      // frame_req and flag_clr together: the drop must still be recorded
      if (i == 2) begin frame_req = 1'b1; flag_clr = 1'b1; end
      @(negedge clk);
      frame_req = 1'b0; flag_clr = 1'b0;
    end
    n_cmp++; if (frame_drop !== 1'b1) begin n_mis++; $display("FAIL hold_drop: got %b expected 1", frame_drop); end
    fifo_full = 1'b0;
    @(negedge clk);
    n_cmp++; if (data_wr !== 1'b1 || data_out !== exp_d) begin
      n_mis++; $display("FAIL release_wr: got wr=%b data=%h expected wr=1 data=%h", data_wr, data_out, exp_d);
    end
    @(negedge clk);
    n_cmp++; if (data_wr !== 1'b0) begin n_mis++; $display("FAIL release_pulse: got %b expected 0", data_wr); end
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    n_cmp++; if (frame_drop !== 1'b0) begin n_mis++; $display("FAIL drop_clr: got %b expected 0", frame_drop); end
  endtask

  task automatic test_stop_and_reset();
    bit saw_wr;
    do_reset();
    cfg(2, 16'h0040, 16'h0050, 8'd255, 1'b0);
    voice_trigger = 4'b0100; voice_stop = 4'b0100;
    @(negedge clk);
    voice_trigger = '0; voice_stop = '0;
    n_cmp++; if (voice_active !== 4'b0000) begin n_mis++; $display("FAIL stop_wins: got %b expected 0000", voice_active); end
    trig(4'b0100);
    n_cmp++; if (voice_active !== 4'b0100) begin n_mis++; $display("FAIL trig_v2: got %b expected 0100", voice_active); end
    voice_stop = 4'b0100;
    @(negedge clk);
    voice_stop = '0;
    n_cmp++; if (voice_active !== 4'b0000) begin n_mis++; $display("FAIL stop_v2: got %b expected 0000", voice_active); end
    cfg(0, 16'h0033, 16'h0040, 8'd200, 1'b1);
    trig(4'b0001);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    n_cmp++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 16'h0033) begin
      n_mis++; $display("FAIL fetch_rd: got en=%b addr=%h expected en=1 addr=0033", mem_rd_en, mem_rd_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mem_rd_en, data_wr, clip, frame_drop} !== 4'b0 || voice_active !== 4'h0 || data_out !== '0) begin
      n_mis++; $display("FAIL midreset_outs: got flags=%b active=%b data=%h expected all 0", {mem_rd_en, data_wr, clip, frame_drop}, voice_active, data_out);
    end
    reset = 1'b1;
    saw_wr = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (data_wr !== 1'b0) saw_wr = 1'b1;
    end
    n_cmp++; if (saw_wr) begin n_mis++; $display("FAIL midreset_nowr: got data_wr=1 expected 0"); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_loop();
    test_wrap();
    test_mix();
    test_clip();
    test_back_to_back();
    test_stop_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sampler_voice_mixer.md
SAMPLER_VOICE_MIXER -- requirements
Module: sampler_voice_mixer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4: number of voices mixed per frame, 1 to 16.
REQ-002 SHALL have parameter SAMPLE_W, default 24: signed per-channel sample width.
REQ-003 SHALL have parameter ADDR_W, default 16: sample memory word address width.
REQ-004 SHALL have parameter VOL_W, default 8: unsigned voice volume width.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- cfg_wr  in  1  write voice config.
- cfg_voice  in  clog2(NUM_VOICES)  target voice.
- cfg_start_addr  in  ADDR_W  first sample address.
- cfg_end_addr  in  ADDR_W  last sample address, inclusive.
- cfg_volume  in  VOL_W  gain.
- cfg_loop  in  1  loop enable.
- voice_trigger  in  NUM_VOICES  per-voice start pulse.
- voice_stop  in  NUM_VOICES  per-voice stop pulse.
- frame_req  in  1  one-cycle sample-rate tick.
- mem_rd_en  out  1  sample memory read strobe.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_data  in  2*SAMPLE_W  {left,right}, valid 1 cycle after mem_rd_en.
- data_out  out  2*SAMPLE_W  mixed frame {left,right}, to codec data FIFO.
- data_wr  out  1  FIFO write strobe.
- fifo_full  in  1  codec FIFO full.
- voice_active  out  NUM_VOICES  per-voice playing flag.
- clip  out  1  sticky saturation flag.
- frame_drop  out  1  sticky missed frame_req flag.
- flag_clr  in  1  clears clip and frame_drop.

Function
REQ-006 SHALL store per voice: start_addr, end_addr, volume, loop, cur_addr, active.
REQ-007 cfg_wr SHALL update config of cfg_voice next cycle; it SHALL NOT change cur_addr or active.
REQ-008 voice_trigger[v] SHALL set cur_addr[v]=start_addr[v] and active[v]=1 next cycle, including when already active (restart).
REQ-009 voice_stop[v] SHALL clear active[v] next cycle; stop SHALL win over a same-cycle trigger or address advance.
REQ-010 FSM states SHALL be IDLE, FETCH, ACCUM, SAT, OUT; reset state IDLE.
REQ-011 IDLE: frame_req -> FETCH with voice index 0 and accumulators cleared.
REQ-012 FETCH(v): mem_rd_en=1, mem_rd_addr=cur_addr[v] only if active[v]; always -> ACCUM(v).
REQ-013 ACCUM(v): if active[v], add (sample*volume)>>>VOL_W per channel, signed, to accumulators of width SAMPLE_W+VOL_W+clog2(NUM_VOICES)+1; inactive voices add 0.
REQ-014 ACCUM(v) advance: cur_addr!=end -> cur_addr+1 (wraps mod 2^ADDR_W); ==end and loop -> start_addr; ==end and !loop -> active cleared; trigger in same cycle overrides advance.
REQ-015 ACCUM(v): v<NUM_VOICES-1 -> FETCH(v+1); else -> SAT.
REQ-016 SAT: each channel clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]; any clamp sets clip; -> OUT.
REQ-017 OUT: if !fifo_full, assert data_wr one cycle with data_out held, -> IDLE; else hold in OUT, data_out stable.
REQ-018 Latency: frame_req at cycle T with FIFO not full -> data_wr at T+2+2*NUM_VOICES (T+10 default).
REQ-019 frame_req outside IDLE SHALL be ignored and set frame_drop.
REQ-020 flag_clr SHALL clear clip and frame_drop; same-cycle set SHALL win.
REQ-021 mem_rd_en SHALL be 0 outside FETCH.

Reset
REQ-022 reset low at a clock edge: state IDLE; all config, cur_addr, accumulators zero; voice_active, mem_rd_en, data_wr, clip, frame_drop 0; data_out 0; mid-frame reset abandons the frame, no data_wr.

Verification
REQ-023 V1: voice 0 start=0x10, end=0x12, vol=255, no loop, trigger, memory returns {1000,-1000}, 4 frame_req -> three frames {996,-997}, fourth {0,0}, voice_active[0] cleared after third.
REQ-024 V2: same with loop=1 -> addresses 0x10,0x11,0x12,0x10,0x11 over 5 frames; voice stays active.
REQ-025 V3: 4 voices all vol=255, samples {0x7FFFFF,0x800000} -> data_out {0x7FFFFF,0x800000}, clip=1; flag_clr -> clip=0.
REQ-026 V4: fifo_full held 5 cycles in OUT -> data_wr 1 cycle after release, data_out unchanged; frame_req during hold -> frame_drop=1.
REQ-027 V5: voice_trigger and voice_stop same cycle on voice 2 -> voice_active[2]=0; reset low mid-FETCH -> IDLE, no data_wr, all outputs 0.
